// File: rtl/norm_left_shift_seq.sv
// Sequential mantissa normalizer: shifts an unnormalized mantissa left up to
// 8 bit positions per cycle. The exponent is decremented to match but never drops below 1.
module norm_left_shift_seq #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_subnormal
);

  // state | meaning
  // IDLE  | waiting for an operand; in_ready high
  // SHIFT | working registers m/e being normalized, one rule per cycle
  // DONE  | result registered; out_valid high until out_ready
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int MSB = MANT_W - 1;

  state_t             state_q, state_d;
  logic [MANT_W-1:0]  m_q, m_d;
  logic [EXP_W-1:0]   e_q, e_d;
  logic [MANT_W-1:0]  out_mant_q, out_mant_d;
  logic [EXP_W-1:0]   out_exp_q, out_exp_d;
  logic               zero_q, zero_d;
  logic               sub_q, sub_d;

  logic [7:0]         top_byte;
  logic [3:0]         k;
  logic [EXP_W-1:0]   k_ext;
  logic [EXP_W-1:0]   e_m1;
  logic [EXP_W-1:0]   s;

  assign top_byte = m_q[MSB -: 8];

  // Leading-zero count of the top byte; the highest set bit wins, 8 when empty.
  always_comb begin
    k = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (top_byte[i]) k = 4'(7 - i);
    end
  end

  // Only used when e_q >= 2, so e_m1 >= 1 and s >= 1 always makes progress.
  assign k_ext = EXP_W'(k);
  assign e_m1  = e_q - EXP_W'(1);
  assign s     = (e_m1 < k_ext) ? e_m1 : k_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      m_q        <= '0;
      e_q        <= '0;
      out_mant_q <= '0;
      out_exp_q  <= '0;
      zero_q     <= 1'b0;
      sub_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      e_q        <= e_d;
      out_mant_q <= out_mant_d;
      out_exp_q  <= out_exp_d;
      zero_q     <= zero_d;
      sub_q      <= sub_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    e_d        = e_q;
    out_mant_d = out_mant_q;
    out_exp_d  = out_exp_q;
    zero_d     = zero_q;
    sub_d      = sub_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = in_mant;
          e_d     = in_exp;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (m_q == '0) begin
          out_mant_d = '0;
          out_exp_d  = '0;
          zero_d     = 1'b1;
          sub_d      = 1'b0;
          state_d    = DONE;
        end else if (m_q[MSB]) begin
          out_mant_d = m_q;
          out_exp_d  = e_q;
          zero_d     = 1'b0;
          sub_d      = 1'b0;
          state_d    = DONE;
        end else if (e_q <= EXP_W'(1)) begin
          out_mant_d = m_q;
          out_exp_d  = '0;
          zero_d     = 1'b0;
          sub_d      = 1'b1;
          state_d    = DONE;
        end else begin
          m_d = m_q << s;
          e_d = e_q - s;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready      = (state_q == IDLE) && !rst;
  assign out_valid     = (state_q == DONE);
  assign out_mant      = out_mant_q;
  assign out_exp       = out_exp_q;
  assign out_zero      = zero_q;
  assign out_subnormal = sub_q;

endmodule

// File: tb/tb_norm_left_shift_seq.sv
// Bench for norm_left_shift_seq: directed corner operands plus random ones,
// compared against a whole-mantissa leading-zero reference model.
module tb_norm_left_shift_seq;

  localparam int MW = 24;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [MW-1:0] in_mant;
  logic [EW-1:0] in_exp;
  logic          out_valid, out_ready;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic          out_zero, out_subnormal;

  int n_tests = 0;
  int n_fail  = 0;

  norm_left_shift_seq #(.MANT_W(MW), .EXP_W(EW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp),
    .out_zero(out_zero), .out_subnormal(out_subnormal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Whole-operand view: normalize by the full leading-zero count, limited so
  // the exponent stays >= 1; 8 positions per cycle sets the latency.
  task automatic ref_model(input logic [MW-1:0] m, input logic [EW-1:0] e,
                           output logic [MW-1:0] rm, output logic [EW-1:0] re,
                           output logic rz, output logic rs, output int rlat);
    int lz, sh;
    rz = 0; rs = 0; rlat = 2;
    if (m == 0) begin
      rm = 0; re = 0; rz = 1;
      return;
    end
    lz = 0;
    while (m[MW-1-lz] == 1'b0) lz++;
    if (lz == 0) begin
      rm = m; re = e;
    end else if (e <= 1) begin
      rm = m; re = 0; rs = 1;
    end else begin
      sh = (lz < int'(e) - 1) ? lz : int'(e) - 1;
      rm = m << sh;
      rlat = 2 + (sh + 7) / 8;
      if (sh == lz) re = e - EW'(lz);
      else begin re = 0; rs = 1; end
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_op(input logic [MW-1:0] m, input logic [EW-1:0] e, input int stall);
    logic [MW-1:0] rm; logic [EW-1:0] re; logic rz, rs; int rlat, lat;
    logic [MW-1:0] hm; logic [EW-1:0] he;
    ref_model(m, e, rm, re, rz, rs, rlat);
    wait_ready();
    in_mant = m; in_exp = e; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_mant = MW'($urandom); in_exp = EW'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, rlat);
    chk("out_mant", out_mant, rm);
    chk("out_exp", out_exp, re);
    chk("out_zero", out_zero, rz);
    chk("out_subnormal", out_subnormal, rs);
    chk("in_ready_busy", in_ready, 1'b0);
    hm = out_mant; he = out_exp;
    for (int i = 0; i < stall; i++) begin
      in_valid = (stall == 3) ? 1'b1 : 1'($urandom);
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_mant", out_mant, hm);
      chk("stall_exp", out_exp, he);
      chk("stall_ready", in_ready, 1'b0);
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("release_valid", out_valid, 1'b0);
    chk("release_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [MW-1:0] rm;
    logic [EW-1:0] re;
    rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_mant", out_mant, 0);
    @(negedge clk); rst = 1'b0;
    #1 chk("post_rst_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    do_op(24'h800000, 8'h7F, 0);
    do_op(24'h000001, 8'h7F, 0);
    do_op(24'h000F00, 8'h05, 0);
    do_op(24'h000000, 8'h90, 0);
    do_op(24'h000001, 8'h7F, 3);

    // Reset during the second SHIFT cycle discards the operand.
    wait_ready();
    in_mant = 24'h000001; in_exp = 8'h7F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst_ready", in_ready, 1'b0);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_mant", out_mant, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1 chk("midrst_resume", in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", out_valid, 1'b0);
    end
    do_op(24'h000F00, 8'h05, 1);

    for (int n = 0; n < 40; n++) begin
      logic [MW-1:0] m;
      logic [EW-1:0] e;
      m = MW'($urandom) >> $urandom_range(0, MW);
      e = ($urandom_range(0, 3) == 0) ? EW'($urandom_range(0, 8)) : EW'($urandom);
      do_op(m, e, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/norm_left_shift_seq.md
NORM_LEFT_SHIFT_SEQ -- requirements
Module: norm_left_shift_seq

Interface
REQ-001 SHALL have parameter MANT_W, default 24: mantissa width including hidden bit; a multiple of 8, minimum 16.
REQ-002 SHALL have parameter EXP_W, default 8: biased exponent width.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: input operand valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept an operand.
REQ-007 SHALL have port in_mant, input, MANT_W: unnormalized mantissa, typically an adder/subtractor result.
REQ-008 SHALL have port in_exp, input, EXP_W: biased exponent associated with in_mant.
REQ-009 SHALL have port out_valid, output, 1: normalized result valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-011 SHALL have port out_mant, output, MANT_W: left-shifted mantissa.
REQ-012 SHALL have port out_exp, output, EXP_W: adjusted exponent.
REQ-013 SHALL have port out_zero, output, 1: result is zero.
REQ-014 SHALL have port out_subnormal, output, 1: result is subnormal; out_exp is 0.

Function
REQ-015 SHALL implement an FSM with three states: IDLE, SHIFT and DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE, and SHALL drive in_ready=0 while rst is high.
REQ-017 SHALL, on in_valid&&in_ready at a rising edge, load the working registers m=in_mant and e=in_exp, then enter SHIFT.
REQ-018 SHALL, in each SHIFT cycle, evaluate the following rules in priority order (a terminal rule registers the result and enters DONE):
- (a) m==0: terminal; out_mant=0, out_exp=0, out_zero=1.
- (b) m[MSB]==1: terminal; out_mant=m, out_exp=e, both flags 0 (applies even when e==0).
- (c) e<=1: terminal; out_mant=m, out_exp=0, out_subnormal=1.
- (d) otherwise: shift m left by s=min(k, e-1) and set e=e-s, zero-filling on the right; remain in SHIFT.
REQ-019 SHALL compute k as the leading-zero count of m[MSB:MSB-7] (0..7), or 8 when that byte is all zero; at most 8 positions per cycle.
REQ-020 SHALL give a latency from the accepting edge to out_valid of 2 edges plus one per rule-(d) cycle; maximum 2+ceil((MANT_W-1)/8) edges.
REQ-021 SHALL, in DONE, assert out_valid=1 and hold out_mant, out_exp, out_zero and out_subnormal stable until out_valid&&out_ready.
REQ-022 SHALL, on out_valid&&out_ready, return to IDLE; out_valid=0 the next cycle; no same-cycle accept (one operand in flight).
REQ-023 SHALL ignore in_valid in SHIFT and DONE; inputs SHALL be sampled only at the accepting edge.
REQ-024 SHALL never let e underflow: s<=e-1 is guaranteed by the min() in rule (d).
REQ-025 SHALL hold out_mant, out_exp and the flags at their last values in IDLE; they are meaningful only while out_valid=1.

Reset
REQ-026 SHALL, on rst assertion in any state (including mid-SHIFT or in DONE with out_ready low), immediately force state=IDLE and clear all registers.
REQ-027 SHALL hold all outputs at 0 while rst is high; the in-flight operand is discarded.
REQ-028 SHALL resume after rst deassertion with in_ready=1 from the first edge.

Verification
REQ-029 SHALL cover: in_mant=0x800000, in_exp=0x7F -> out_valid at edge 2; out_mant=0x800000, out_exp=0x7F, flags 0.
REQ-030 SHALL cover: in_mant=0x000001, in_exp=0x7F -> shifts 8, 8, 7; out_valid at edge 5; out_mant=0x800000, out_exp=0x68.
REQ-031 SHALL cover: in_mant=0x000F00, in_exp=0x05 -> one shift of 4; out_mant=0x00F000, out_exp=0x00, out_subnormal=1, out_valid at edge 3.
REQ-032 SHALL cover: in_mant=0x000000, in_exp=0x90 -> out_valid at edge 2; out_zero=1, out_mant=0, out_exp=0.
REQ-033 SHALL cover: result pending with out_ready=0 for 3 cycles and in_valid=1 throughout -> outputs stable, in_ready=0, no second accept; on out_ready=1 -> IDLE, then in_ready=1.
REQ-034 SHALL cover: rst pulsed in the second SHIFT cycle of the REQ-030 operand -> out_valid never asserts for it; in_ready=1 after release; next operand processed correctly.
